// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file read-port block.
package rf_pkg;

    localparam int unsigned NREGS = 8;
    localparam int unsigned AW    = $clog2(NREGS);
    localparam int unsigned DW    = 32;

    typedef logic [AW-1:0] rf_addr_t;
    typedef logic [DW-1:0] rf_data_t;

    typedef struct packed {
        rf_addr_t addr;
        rf_data_t data;
    } rf_rsp_t;

    function automatic logic addr_in_range(input rf_addr_t a);
        return (32'(a) < NREGS);
    endfunction

endpackage

// File: rtl/rf_rsp_fifo2.sv
// Two-entry response FIFO; head is a dedicated register so outputs hold after the last pop.
module rf_rsp_fifo2
    import rf_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    in_valid,
    output logic    in_ready,
    input  rf_rsp_t in_data,
    output logic    out_valid,
    input  logic    out_ready,
    output rf_rsp_t out_data
);

    rf_rsp_t    head_q, head_d;
    rf_rsp_t    tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;

    always_comb begin
        push    = in_valid && in_ready;
        pop     = out_valid && out_ready;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = in_data;
                else                 tail_d = in_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                // With one entry left the head keeps the popped value on the outputs.
                if (count_q == 2'd2) head_d = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Only reachable with count 1: the new entry replaces the departing head.
                head_d = in_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rf_read_port.sv
// Register file with one write port and a handshaked, buffered read port.
// Define RF_RD_BYPASS_EN to forward same-cycle write data into a read of the same index.
module rf_read_port
    import rf_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     wr_en,
    input  rf_addr_t wr_addr,
    input  rf_data_t wr_data,
    input  logic     rd_req_valid,
    output logic     rd_req_ready,
    input  rf_addr_t rd_req_addr,
    output logic     rd_rsp_valid,
    input  logic     rd_rsp_ready,
    output rf_data_t rd_rsp_data,
    output rf_addr_t rd_rsp_addr
);

    rf_data_t         rf_q [NREGS];
    rf_data_t         rf_d [NREGS];
    logic [NREGS-1:0] we;
    rf_data_t         rd_data;
    rf_rsp_t          req_rsp;
    rf_rsp_t          head_rsp;

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            we[i]   = wr_en && (wr_addr == AW'(i));
            rf_d[i] = we[i] ? wr_data : rf_q[i];
        end
    end

    always_comb begin
        rd_data = '0;
        if (addr_in_range(rd_req_addr)) begin
            rd_data = rf_q[rd_req_addr];
`ifdef RF_RD_BYPASS_EN
            if (wr_en && (wr_addr == rd_req_addr)) rd_data = wr_data;
`endif
        end
        req_rsp.addr = rd_req_addr;
        req_rsp.data = rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
        end
    end

    rf_rsp_fifo2 u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_req_valid),
        .in_ready  (rd_req_ready),
        .in_data   (req_rsp),
        .out_valid (rd_rsp_valid),
        .out_ready (rd_rsp_ready),
        .out_data  (head_rsp)
    );

    assign rd_rsp_data = head_rsp.data;
    assign rd_rsp_addr = head_rsp.addr;

endmodule

// File: tb/tb_rf_read_port.sv
// Bench for rf_read_port: directed scenarios plus random traffic against a scoreboard.
module tb_rf_read_port;
    import rf_pkg::*;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    logic     wr_en = 1'b0;
    rf_addr_t wr_addr = '0;
    rf_data_t wr_data = '0;
    logic     rd_req_valid = 1'b0;
    logic     rd_req_ready;
    rf_addr_t rd_req_addr = '0;
    logic     rd_rsp_valid;
    logic     rd_rsp_ready = 1'b0;
    rf_data_t rd_rsp_data;
    rf_addr_t rd_rsp_addr;

    int checks = 0;
    int errors = 0;

    // Reference model: plain register array plus queue of expected responses.
    logic [31:0] model_rf [NREGS];
    rf_rsp_t     exp_q [$];
    rf_rsp_t     last_pop;

    always #5 clk = ~clk;

    rf_read_port dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_ready (rd_rsp_ready),
        .rd_rsp_data  (rd_rsp_data),
        .rd_rsp_addr  (rd_rsp_addr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: everything is sampled at the falling edge, where inputs and
    // outputs are stable and describe what the next rising edge will do.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) model_rf[i] = '0;
            exp_q.delete();
            last_pop = '0;
        end else begin
            check("rsp_valid", 32'(rd_rsp_valid), 32'(exp_q.size() != 0));
            check("req_ready", 32'(rd_req_ready), 32'(exp_q.size() < 2));
            if (rd_rsp_valid && exp_q.size() != 0) begin
                check("rsp_data", rd_rsp_data, exp_q[0].data);
                check("rsp_addr", 32'(rd_rsp_addr), 32'(exp_q[0].addr));
                if (rd_rsp_ready) last_pop = exp_q.pop_front();
            end else if (!rd_rsp_valid) begin
                check("idle_data_hold", rd_rsp_data, last_pop.data);
                check("idle_addr_hold", 32'(rd_rsp_addr), 32'(last_pop.addr));
            end
            if (rd_req_valid && rd_req_ready) begin
                rf_rsp_t e;
                e.addr = rd_req_addr;
                e.data = (32'(rd_req_addr) < NREGS) ? model_rf[rd_req_addr] : '0;
`ifdef RF_RD_BYPASS_EN
                if (wr_en && wr_addr == rd_req_addr && 32'(wr_addr) < NREGS) e.data = wr_data;
`endif
                exp_q.push_back(e);
            end
            if (wr_en && 32'(wr_addr) < NREGS) model_rf[wr_addr] = wr_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en        = 1'b0;
        rd_req_valid = 1'b0;
    endtask

    task automatic write(input rf_addr_t a, input rf_data_t d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    // Holds the request until accepted, giving up after a cycle budget.
    task automatic read(input rf_addr_t a);
        bit done = 0;
        rd_req_valid = 1'b1; rd_req_addr = a;
        for (int i = 0; i < 20 && !done; i++) begin
            if (rd_req_ready) done = 1;
            step();
        end
        rd_req_valid = 1'b0;
        if (!done) check("read_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done = 0;
        rd_rsp_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (!rd_rsp_valid) done = 1;
            else step();
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        check("reset_valid", 32'(rd_rsp_valid), 32'd0);
        check("reset_data", rd_rsp_data, 32'd0);

        // Basic write then read with one-cycle latency.
        rd_rsp_ready = 1'b1;
        write(3'd3, 32'hDEADBEEF);
        rd_req_valid = 1'b1; rd_req_addr = 3'd3;
        step();
        rd_req_valid = 1'b0;
        check("t1_latency_valid", 32'(rd_rsp_valid), 32'd1);
        check("t1_data", rd_rsp_data, 32'hDEADBEEF);
        step();

        // Backpressure: third request stalls until the buffer drains.
        rd_rsp_ready = 1'b0;
        write(3'd1, 32'h1111_0001);
        write(3'd2, 32'h2222_0002);
        write(3'd4, 32'h4444_0004);
        read(3'd1);
        read(3'd2);
        rd_req_valid = 1'b1; rd_req_addr = 3'd4;
        step();
        check("t2_full_ready", 32'(rd_req_ready), 32'd0);
        rd_rsp_ready = 1'b1;
        read(3'd4);
        drain();

        // Same-cycle write and read of r5.
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h1234;
        rd_req_valid = 1'b1; rd_req_addr = 3'd5;
        step();
        idle_inputs();
`ifdef RF_RD_BYPASS_EN
        check("t3_bypass", rd_rsp_data, 32'h1234);
`else
        check("t3_no_bypass", rd_rsp_data, 32'h0);
`endif
        drain();

        // Snapshot: buffered data unaffected by a later write.
        write(3'd6, 32'hA5A5A5A5);
        rd_rsp_ready = 1'b0;
        read(3'd6);
        write(3'd6, 32'h0);
        step();
        check("t4_snapshot", rd_rsp_data, 32'hA5A5A5A5);
        drain();

        // Steady push+pop at count 1.
        rd_rsp_ready = 1'b0;
        read(3'd3);
        rd_rsp_ready = 1'b1;
        rd_req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rd_req_addr = rf_addr_t'($urandom_range(0, NREGS - 1));
            step();
            check("t5_count_one", 32'(rd_rsp_valid && rd_req_ready), 32'd1);
        end
        rd_req_valid = 1'b0;
        drain();

        // Reset while full and writing.
        rd_rsp_ready = 1'b0;
        read(3'd1);
        read(3'd2);
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 32'hFFFF_FFFF;
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr_en = 1'b0;
        check("t6_rst_valid", 32'(rd_rsp_valid), 32'd0);
        check("t6_rst_ready", 32'(rd_req_ready), 32'd1);
        check("t6_rst_data", rd_rsp_data, 32'd0);
        rd_rsp_ready = 1'b1;
        for (int i = 0; i < NREGS; i++) read(rf_addr_t'(i));
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            wr_en        = ($urandom_range(0, 2) == 0);
            wr_addr      = rf_addr_t'($urandom_range(0, NREGS - 1));
            wr_data      = $urandom;
            rd_req_valid = ($urandom_range(0, 1) == 1);
            rd_req_addr  = ($urandom_range(0, 3) == 0) ? wr_addr
                                                       : rf_addr_t'($urandom_range(0, NREGS - 1));
            rd_rsp_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        idle_inputs();
        drain();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
